// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: host sequencer for a LENGTH-deep shift register (WRITE_VEC/READ_VEC/LOAD/UPLOAD).
// Optional wr_last framing check is enabled with SHIFT_REG_CTRL_LAST_CHECK_EN.
module shift_reg_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic signed [DATA_WIDTH-1:0] wr_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic signed [DATA_WIDTH-1:0] rd_data,
  output logic                         rd_last,
  output logic                         done,
  output logic [1:0]                   sr_ctrl_code,
  output logic signed [DATA_WIDTH-1:0] sr_data_write,
  input  logic signed [DATA_WIDTH-1:0] sr_data_read
`ifdef SHIFT_REG_CTRL_LAST_CHECK_EN
  ,
  input  logic                         wr_last,
  output logic                         err_last
`endif
);
  localparam int CW = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_SINGLE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_wr_cnt, r_rd_cnt;
  logic [1:0] r_op, r_count, w_eff;
  logic r_in_flight, r_if_last, r_done;
  logic signed [DATA_WIDTH-1:0] r_buf_data [2];
  logic [1:0] r_buf_last;
  logic w_cmd_acc, w_wr_acc, w_issue, w_pop, w_slot;
  assign w_cmd_acc = reset_n && cmd_valid && r_state == S_IDLE;
  assign w_wr_acc  = reset_n && wr_valid && r_state == S_WRITE;
  assign w_pop     = rd_valid && rd_ready;
  // Occupancy after this cycle's pop plus the read already in flight; keeps 1 word/cycle.
  assign w_eff     = r_count - 2'(w_pop) + 2'(r_in_flight);
  assign w_issue   = reset_n && r_state == S_READ && w_eff < 2'd2;
  assign w_slot    = (r_count - 2'(w_pop)) != 2'd0;
  assign rd_valid  = r_count != 2'd0;
  assign rd_data   = r_buf_data[0];
  assign rd_last   = rd_valid && r_buf_last[0];
  assign done      = r_done;
  always_ff @(posedge clk)
    r_state <= !reset_n ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cmd_acc) w_next = cmd_op == 2'd0 ? S_WRITE : cmd_op == 2'd1 ? S_READ : S_SINGLE;
      S_WRITE: if (w_wr_acc && r_wr_cnt == LAST) w_next = S_IDLE;
      S_READ:  if (w_issue && r_rd_cnt == LAST) w_next = S_DRAIN;
      S_DRAIN: if (r_count == 2'd0 && !r_in_flight) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    cmd_ready     = reset_n && r_state == S_IDLE;
    wr_ready      = reset_n && r_state == S_WRITE;
    sr_ctrl_code  = w_wr_acc ? 2'd2 : w_issue ? 2'd3
                  : (reset_n && r_state == S_SINGLE && r_op == 2'd2) ? 2'd1 : 2'd0;
    sr_data_write = w_wr_acc ? wr_data : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_cnt      <= '0;
      r_rd_cnt      <= '0;
      r_op          <= '0;
      r_count       <= '0;
      r_in_flight   <= 1'b0;
      r_if_last     <= 1'b0;
      r_done        <= 1'b0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last    <= '0;
    end else begin
      r_done      <= r_state != S_IDLE && w_next == S_IDLE;
      r_in_flight <= w_issue;
      r_if_last   <= w_issue && r_rd_cnt == LAST;
      r_count     <= r_count + 2'(r_in_flight) - 2'(w_pop);
      if (w_cmd_acc) begin
        r_op     <= cmd_op;
        r_wr_cnt <= '0;
        r_rd_cnt <= '0;
      end
      if (w_wr_acc) r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_issue) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_pop) begin
        r_buf_data[0] <= r_buf_data[1];
        r_buf_last[0] <= r_buf_last[1];
      end
      // The returning read lands in the first free slot after the pop; later NBA wins.
      if (r_in_flight) begin
        r_buf_data[w_slot] <= sr_data_read;
        r_buf_last[w_slot] <= r_if_last;
      end
    end
  end
`ifdef SHIFT_REG_CTRL_LAST_CHECK_EN
  logic r_err_last;
  assign err_last = r_err_last;
  always_ff @(posedge clk) begin
    if (!reset_n) r_err_last <= 1'b0;
    else if (w_wr_acc && (wr_last != (r_wr_cnt == LAST))) r_err_last <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl: randomized self-checking bench with a behavioural shift-register model.
module tb_shift_reg_ctrl;
  localparam int DW = 8;
  localparam int L  = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic wr_valid = 1'b0, wr_ready;
  logic signed [DW-1:0] wr_data = '0;
  logic rd_valid, rd_ready = 1'b0, rd_last, done;
  logic signed [DW-1:0] rd_data;
  logic [1:0] sr_ctrl_code;
  logic signed [DW-1:0] sr_data_write, sr_q;
  logic wr_last = 1'b0, err_last;
  logic exp_err = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic signed [DW-1:0] wvec [L];
  logic signed [DW-1:0] exp_reg [L];
  logic signed [DW-1:0] sr_mem [L];

  always #5 clk = ~clk;

  shift_reg_ctrl #(.DATA_WIDTH(DW), .LENGTH(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .sr_ctrl_code(sr_ctrl_code), .sr_data_write(sr_data_write),
    .sr_data_read(sr_q)
`ifdef SHIFT_REG_CTRL_LAST_CHECK_EN
    , .wr_last(wr_last), .err_last(err_last)
`endif
  );

`ifndef SHIFT_REG_CTRL_LAST_CHECK_EN
  assign err_last = 1'b0;
`endif

  // The shift register being driven: WRITE shifts in at the top, READ rotates and returns index 0.
  always @(posedge clk) begin
    if (sr_ctrl_code == 2'd2) begin
      for (int i = 0; i < L - 1; i++) sr_mem[i] <= sr_mem[i+1];
      sr_mem[L-1] <= sr_data_write;
    end else if (sr_ctrl_code == 2'd3) begin
      sr_q <= sr_mem[0];
      for (int i = 0; i < L - 1; i++) sr_mem[i] <= sr_mem[i+1];
      sr_mem[L-1] <= sr_mem[0];
    end
  end

  task automatic do_cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op = op;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1 || sr_ctrl_code !== 2'd0) begin
      n_fail++;
      $display("FAIL cmd_accept op=%0d: cmd_ready=%b code=%0d, required 1 and 0", op, cmd_ready, sr_ctrl_code);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({cmd_ready, wr_ready, rd_valid, rd_last, done, err_last} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: cmd_ready,wr_ready,rd_valid,rd_last,done,err_last=%b required 000000",
               {cmd_ready, wr_ready, rd_valid, rd_last, done, err_last});
    end
    n_chk++;
    if (sr_ctrl_code !== 2'd0 || sr_data_write !== '0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_data: code=%0d data_write=%0d rd_data=%0d required 0 0 0", sr_ctrl_code, sr_data_write, rd_data);
    end
    exp_err = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
  endtask

  // gaps: 1 = strict 1,0,1,0 wr_valid pattern, 0 = random; bad_idx >= 0 puts wr_last on that word only
  task automatic test_write(input int gaps, input int bad_idx);
    int k, cyc;
    logic exp_code;
    k = 0; cyc = 0;
    do_cmd(2'd0);
    while (k < L && cyc < 64) begin
      wr_valid = gaps ? (cyc % 2 == 0) : 1'($urandom_range(1));
      wr_data = wr_valid ? wvec[k] : DW'($urandom);
      wr_last = wr_valid && ((bad_idx >= 0) ? (k == bad_idx) : (k == L - 1));
      #1;
      n_chk++;
      if ({wr_ready, cmd_ready, done} !== 3'b100) begin
        n_fail++;
        $display("FAIL write_flags cyc=%0d: wr_ready,cmd_ready,done=%b required 100", cyc, {wr_ready, cmd_ready, done});
      end
      exp_code = wr_valid;
      n_chk++;
      if (sr_ctrl_code !== (exp_code ? 2'd2 : 2'd0) || (exp_code && sr_data_write !== wvec[k])) begin
        n_fail++;
        $display("FAIL write_code cyc=%0d: code=%0d data=%0d required %0d %0d", cyc, sr_ctrl_code, sr_data_write,
                 exp_code ? 2 : 0, wvec[k]);
      end
`ifdef SHIFT_REG_CTRL_LAST_CHECK_EN
      n_chk++;
      if (err_last !== exp_err) begin
        n_fail++;
        $display("FAIL err_last cyc=%0d: got %b required %b", cyc, err_last, exp_err);
      end
      if (wr_valid && (wr_last != (k == L - 1))) exp_err = 1'b1;
`endif
      if (wr_valid) k++;
      cyc++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wr_last = 1'b0;
    #1;
    n_chk++;
    if (k != L || {done, cmd_ready, wr_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL write_done: words=%0d done,cmd_ready,wr_ready=%b required %0d and 110", k, {done, cmd_ready, wr_ready}, L);
    end
    n_chk++;
    if (err_last !== exp_err) begin
      n_fail++;
      $display("FAIL err_last_end: got %b required %b", err_last, exp_err);
    end
    exp_reg = wvec;
    @(negedge clk);
    #1;
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL write_done_pulse: done=%b required 0", done);
    end
    @(negedge clk);
  endtask

  // pct: rd_ready probability in percent; hold: leading cycles with rd_ready forced low
  task automatic test_read(input int pct, input int hold);
    int got, issues, cyc, first, lastc;
    logic seen_done, prev_hold;
    logic signed [DW-1:0] prev_data;
    got = 0; issues = 0; cyc = 0; first = -1; lastc = -1;
    seen_done = 1'b0; prev_hold = 1'b0; prev_data = '0;
    rd_ready = 1'b0;
    do_cmd(2'd1);
    while (!seen_done && cyc < 200) begin
      rd_ready = (cyc < hold) ? 1'b0 : ($urandom_range(99) < pct);
      #1;
      if (sr_ctrl_code == 2'd3) issues++;
      n_chk++;
      if (sr_ctrl_code !== 2'd0 && sr_ctrl_code !== 2'd3) begin
        n_fail++;
        $display("FAIL read_code cyc=%0d: code=%0d required 0 or 3", cyc, sr_ctrl_code);
      end
      if (hold >= 3 && cyc == hold - 1) begin
        n_chk++;
        if (issues > 2 || rd_valid !== 1'b1 || rd_data !== exp_reg[0]) begin
          n_fail++;
          $display("FAIL read_backpressure: issues=%0d rd_valid=%b rd_data=%0d required <=2 1 %0d", issues, rd_valid, rd_data, exp_reg[0]);
        end
      end
      if (prev_hold) begin
        n_chk++;
        if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
          n_fail++;
          $display("FAIL read_hold cyc=%0d: rd_valid=%b rd_data=%0d required 1 %0d", cyc, rd_valid, rd_data, prev_data);
        end
      end
      if (done === 1'b1) begin
        seen_done = 1'b1;
        n_chk++;
        if (got != L || issues != L || cmd_ready !== 1'b1 || rd_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL read_done: words=%0d issues=%0d cmd_ready=%b rd_valid=%b required %0d %0d 1 0",
                   got, issues, cmd_ready, rd_valid, L, L);
        end
      end else if (rd_valid && rd_ready) begin
        n_chk++;
        if (got >= L || rd_data !== exp_reg[got] || rd_last !== (got == L - 1)) begin
          n_fail++;
          $display("FAIL read_word idx=%0d: data=%0d last=%b required %0d %b", got, rd_data, rd_last,
                   (got < L) ? exp_reg[got] : 0, got == L - 1);
        end
        if (first < 0) first = cyc;
        lastc = cyc;
        got++;
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
      cyc++;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    if (!seen_done) begin
      n_chk++;
      n_fail++;
      $display("FAIL read_timeout: no done after %0d cycles, words=%0d", cyc, got);
    end
    if (pct == 100 && hold == 0) begin
      n_chk++;
      if (lastc - first != L - 1) begin
        n_fail++;
        $display("FAIL read_throughput: span=%0d cycles required %0d", lastc - first, L - 1);
      end
    end
    #1;
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL read_done_pulse: done=%b required 0", done);
    end
    @(negedge clk);
  endtask

  task automatic test_single(input logic [1:0] op);
    do_cmd(op);
    #1;
    n_chk++;
    if (sr_ctrl_code !== ((op == 2'd2) ? 2'd1 : 2'd0) || done !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_issue op=%0d: code=%0d done=%b cmd_ready=%b required %0d 0 0", op, sr_ctrl_code, done, cmd_ready,
               (op == 2'd2) ? 1 : 0);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || sr_ctrl_code !== 2'd0) begin
      n_fail++;
      $display("FAIL single_done op=%0d: done=%b cmd_ready=%b code=%0d required 1 1 0", op, done, cmd_ready, sr_ctrl_code);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_pulse op=%0d: done=%b required 0", op, done);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    do_cmd(2'd2);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'd3;
    #1;
    n_chk++;
    if (done !== 1'b1 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: done=%b cmd_ready=%b required 1 1", done, cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b0 || sr_ctrl_code !== 2'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_single: cmd_ready=%b code=%0d done=%b required 0 0 0", cmd_ready, sr_ctrl_code, done);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b required 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    int issues, cyc;
    issues = 0; cyc = 0;
    rd_ready = 1'b0;
    do_cmd(2'd1);
    while (issues < 2 && cyc < 20) begin
      #1;
      if (sr_ctrl_code == 2'd3) issues++;
      cyc++;
      @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (issues != 2 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_assert: issues=%0d cmd_ready=%b required 2 0", issues, cmd_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd_ready = 1'b1;
    exp_err = 1'b0;
    #1;
    n_chk++;
    if ({rd_valid, cmd_ready, done, rd_last} !== 4'b0100 || sr_ctrl_code !== 2'd0) begin
      n_fail++;
      $display("FAIL midreset_release: rd_valid,cmd_ready,done,rd_last=%b code=%0d required 0100 0",
               {rd_valid, cmd_ready, done, rd_last}, sr_ctrl_code);
    end
    @(negedge clk);
    #1;
    n_chk++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_empty: rd_valid=%b required 0", rd_valid);
    end
    rd_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic randomize_vec;
    for (int i = 0; i < L; i++) wvec[i] = DW'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    wvec[0] = 8'sd5; wvec[1] = -8'sd3; wvec[2] = 8'sd7; wvec[3] = 8'sd1;
    test_write(1, -1);
    test_read(100, 0);
    test_read(100, 0);
    test_read(100, 5);
    test_single(2'd2);
    test_single(2'd3);
    test_back_to_back;
    for (int n = 0; n < 6; n++) begin
      randomize_vec;
      test_write(0, -1);
      test_read($urandom_range(30, 100), $urandom_range(0, 4));
      test_read($urandom_range(30, 100), 0);
    end
    test_reset_mid_read;
    randomize_vec;
    test_write(0, -1);
    test_read(100, 0);
`ifdef SHIFT_REG_CTRL_LAST_CHECK_EN
    randomize_vec;
    test_write(0, 1);
    test_single(2'd3);
    n_chk++;
    if (err_last !== 1'b1) begin
      n_fail++;
      $display("FAIL err_last_sticky: got %b required 1", err_last);
    end
    test_reset;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
